// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared seven-segment types, glyph table and decode function
package seven_seg_pkg;

  typedef logic [6:0] seg7_t;

  // Bit order is abcdefg, with seg[6] = a.
  localparam seg7_t SEG_BLANK = 7'b0000000;

  localparam seg7_t SEG_HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-high seven-segment decoder
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - time-multiplexed hex display scanner with frame-synchronous update
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter bit SEG_INVERT  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame_start,
  output logic                    upd_pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = $clog2(REFRESH_DIV);
  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [PS_W-1:0]         presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, disp_data_q, src_data;
  logic [NUM_DIGITS-1:0]   pend_en_q, disp_en_q, src_en;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  seg7_t                   seg_q, seg_d, dec_seg;
  logic                    frame_start_q, upd_pending_q;
  logic                    tick, wrap, commit, lit;
  logic [3:0]              nibble;

  always_comb begin
    tick    = (presc_q == PS_MAX);
    wrap    = tick && (idx_q == IDX_MAX);
    commit  = wrap && upd_pending_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    // Digit 0 of a committing frame is drawn from the pending buffer so the frame never tears.
    src_data = commit ? pend_data_q : disp_data_q;
    src_en   = commit ? pend_en_q   : disp_en_q;
    nibble   = 4'h0;
    lit      = 1'b0;
    an_d     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nibble  = src_data[4*i +: 4];
        lit     = src_en[i];
        an_d[i] = ~src_en[i];
      end
    end
    seg_d = (lit ? dec_seg : SEG_BLANK) ^ {7{SEG_INVERT}};
  end

  hex_to_seg7 u_dec (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= IDX_MAX;
      pend_data_q   <= '0;
      disp_data_q   <= '0;
      pend_en_q     <= '0;
      disp_en_q     <= '0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
      upd_pending_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      frame_start_q <= wrap;
      if (tick) begin
        idx_q <= idx_d;
        an_q  <= an_d;
        seg_q <= seg_d;
      end
      if (commit) begin
        disp_data_q <= pend_data_q;
        disp_en_q   <= pend_en_q;
      end
      // A load on the wrap edge keeps the flag set for the following frame.
      if (load) begin
        pend_data_q   <= data;
        pend_en_q     <= digit_en;
        upd_pending_q <= 1'b1;
      end else if (wrap) begin
        upd_pending_q <= 1'b0;
      end
    end
  end

  assign seg         = seg_q;
  assign AN          = an_q;
  assign frame_start = frame_start_q;
  assign upd_pending = upd_pending_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

  localparam int N = 8;
  localparam int R = 4;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] exp_seg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, load;
  logic [31:0] data;
  logic [7:0]  den;
  logic [6:0]  seg, seg_inv;
  logic [7:0]  an, an_inv;
  logic        fs, fs_inv, up, up_inv;

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;
  vec_t tbl [16];

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_INVERT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .digit_en(den),
    .seg(seg), .AN(an), .frame_start(fs), .upd_pending(up)
  );

  seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_INVERT(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .digit_en(den),
    .seg(seg_inv), .AN(an_inv), .frame_start(fs_inv), .upd_pending(up_inv)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: elapsed cycles since reset release decide slot and frame.
  int          k, mn, md;
  logic [31:0] m_disp, m_pend;
  logic [7:0]  m_disp_en, m_pend_en;
  bit          m_has;
  logic [7:0]  e_an;
  logic [6:0]  e_seg, e_seg_inv;
  bit          e_fs;

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0; m_disp = '0; m_pend = '0; m_disp_en = '0; m_pend_en = '0; m_has = 1'b0;
      e_an = 8'hFF; e_seg = '0; e_seg_inv = '0; e_fs = 1'b0;
    end else begin
      k++;
      e_fs = 1'b0;
      if (k % R == 0) begin
        mn = k / R;
        md = (mn - 1) % N;
        if (md == 0) begin
          e_fs = 1'b1;
          if (m_has) begin
            m_disp = m_pend; m_disp_en = m_pend_en; m_has = 1'b0;
          end
        end
        if (m_disp_en[md]) begin
          e_an      = ~(8'h01 << md);
          e_seg     = tbl[m_disp[4*md +: 4]].exp_seg;
          e_seg_inv = ~e_seg;
        end else begin
          e_an = 8'hFF; e_seg = '0; e_seg_inv = 7'h7F;
        end
      end
      if (load) begin
        m_pend = data; m_pend_en = den; m_has = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("model_an", {24'h0, an}, {24'h0, e_an});
      chk("model_seg", {25'h0, seg}, {25'h0, e_seg});
      chk("model_frame_start", {31'h0, fs}, {31'h0, e_fs});
      chk("model_upd_pending", {31'h0, up}, {31'h0, m_has});
      chk("model_inv_an", {24'h0, an_inv}, {24'h0, e_an});
      chk("model_inv_seg", {25'h0, seg_inv}, {25'h0, e_seg_inv});
      chk("model_inv_fs", {31'h0, fs_inv}, {31'h0, e_fs});
    end
  end

  task automatic do_load(input logic [31:0] d, input logic [7:0] en);
    data = d; den = en; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_wrap();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * N * R && !seen; i++) begin
      @(negedge clk);
      seen = fs;
    end
    chk("wrap_seen", {31'h0, seen}, 32'h1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{4'h0, 7'b1111110}; tbl[1]  = '{4'h1, 7'b0110000};
    tbl[2]  = '{4'h2, 7'b1101101}; tbl[3]  = '{4'h3, 7'b1111001};
    tbl[4]  = '{4'h4, 7'b0110011}; tbl[5]  = '{4'h5, 7'b1011011};
    tbl[6]  = '{4'h6, 7'b1011111}; tbl[7]  = '{4'h7, 7'b1110000};
    tbl[8]  = '{4'h8, 7'b1111111}; tbl[9]  = '{4'h9, 7'b1111011};
    tbl[10] = '{4'hA, 7'b1110111}; tbl[11] = '{4'hB, 7'b0011111};
    tbl[12] = '{4'hC, 7'b1001110}; tbl[13] = '{4'hD, 7'b0111101};
    tbl[14] = '{4'hE, 7'b1001111}; tbl[15] = '{4'hF, 7'b1000111};
    rst_n = 1'b0; load = 1'b0; data = '0; den = '0;

    // Reset: blank for REFRESH_DIV cycles, then digit 0 appears with a frame pulse.
    @(negedge clk);
    reset_dut();
    mon_en = 1'b1;
    data = 32'h5; den = 8'h01; load = 1'b1;
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {25'h0, seg}, 32'h0);
    chk("rst_fs", {31'h0, fs}, 32'h0);
    chk("rst_up", {31'h0, up}, 32'h0);
    @(negedge clk);
    load = 1'b0;
    for (int i = 1; i < R; i++) begin
      chk("rst_blank_an", {24'h0, an}, 32'hFF);
      chk("rst_blank_seg", {25'h0, seg}, 32'h0);
      @(negedge clk);
    end
    chk("first_tick_an", {24'h0, an}, 32'hFE);
    chk("first_tick_fs", {31'h0, fs}, 32'h1);
    chk("first_tick_seg", {25'h0, seg}, 32'h5B);
    @(negedge clk);
    chk("fs_one_cycle", {31'h0, fs}, 32'h0);

    // Load during a blank frame 0, scanned from frame 1.
    reset_dut();
    wait_wrap();
    do_load(32'h89AB_CDEF, 8'hFF);
    for (int i = 0; i < N * R - 1; i++) begin
      chk("frame0_blank", {24'h0, an}, 32'hFF);
      @(negedge clk);
    end
    for (int d = 0; d < N; d++) begin
      for (int c = 0; c < R; c++) begin
        chk("scan_an", {24'h0, an}, {24'h0, ~(8'h01 << d)});
        if (d == 0) chk("scan_d0_seg", {25'h0, seg}, 32'h47);
        if (d == 7) chk("scan_d7_seg", {25'h0, seg}, 32'h7F);
        @(negedge clk);
      end
    end

    // Blanking of the upper nibbles.
    do_load(32'h0000_1234, 8'h0F);
    wait_wrap();
    chk("blank_d0_seg", {25'h0, seg}, 32'h33);
    for (int d = 0; d < N; d++) begin
      for (int c = 0; c < R; c++) begin
        if (d >= 4) begin
          chk("blank_an", {24'h0, an}, 32'hFF);
          chk("blank_seg", {25'h0, seg}, 32'h0);
        end else begin
          chk("lit_an", {24'h0, an}, {24'h0, ~(8'h01 << d)});
        end
        @(negedge clk);
      end
    end

    // Load coinciding with the wrap edge.
    wait_wrap();
    do_load(32'h1, 8'h01);
    repeat (N * R - 2) @(negedge clk);
    do_load(32'h2, 8'h01);
    chk("wrapload_fs", {31'h0, fs}, 32'h1);
    chk("wrapload_seg_a", {25'h0, seg}, 32'h30);
    chk("wrapload_up", {31'h0, up}, 32'h1);
    wait_wrap();
    chk("wrapload_seg_b", {25'h0, seg}, 32'h6D);
    chk("wrapload_up_clr", {31'h0, up}, 32'h0);

    // Reset while digit 5 is lit-slot and an update is pending.
    do_load(32'h3, 8'hFF);
    repeat (20) @(negedge clk);
    chk("midrst_pending", {31'h0, up}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_an", {24'h0, an}, 32'hFF);
    chk("midrst_seg", {25'h0, seg}, 32'h0);
    chk("midrst_up", {31'h0, up}, 32'h0);
    chk("midrst_fs", {31'h0, fs}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < R + 2 * N * R; i++) begin
      chk("midrst_blank", {24'h0, an}, 32'hFF);
      @(negedge clk);
    end

    // Inverted cathodes and the full decode table.
    for (int i = 0; i < 16; i++) begin
      do_load({28'h0, tbl[i].nib}, 8'h01);
      wait_wrap();
      chk("dec_an", {24'h0, an}, 32'hFE);
      chk("dec_seg", {25'h0, seg}, {25'h0, tbl[i].exp_seg});
      chk("dec_seg_inv", {25'h0, seg_inv}, {25'h0, ~tbl[i].exp_seg});
    end
    do_load(32'h0, 8'h01);
    wait_wrap();
    chk("inv_zero_seg", {25'h0, seg_inv}, 32'h01);

    // Randomized loads and occasional resets against the model.
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      load  = ($urandom_range(0, 7) == 0);
      data  = $urandom;
      den   = 8'($urandom);
      @(negedge clk);
    end
    load = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
